// File: rtl/pipe_stage_reg_if.sv
// Valid/ready channel carrying one data bundle and one control bundle.
// master drives valid/data/ctrl and samples ready; slave is the mirror.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 13
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input ready);
  modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, 2-entry skid
// buffer, flush and bubble-safe control masking.
// Optional macro PIPE_STAGE_PERF_EN adds saturating stall/bubble counters.
module pipe_stage_reg #(
  parameter int                DATA_W   = 96,
  parameter int                CTRL_W   = 13,
  parameter logic [CTRL_W-1:0] CTRL_RST = '0,
  parameter int                CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  pipe_stage_reg_if.slave      up,
  pipe_stage_reg_if.master     dn
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              ready;
  logic              ready_nxt;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] main_data_nxt;
  logic [CTRL_W-1:0] main_ctrl;
  logic [CTRL_W-1:0] main_ctrl_nxt;
  logic [DATA_W-1:0] skid_data;
  logic [DATA_W-1:0] skid_data_nxt;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [CTRL_W-1:0] skid_ctrl_nxt;
  logic              out_valid;
  logic              accept;
  logic              transfer;

  // Reject nonsensical widths at elaboration time.
  if (DATA_W < 1 || CTRL_W < 1 || CNT_W < 1) begin : g_param_check
    $error("pipe_stage_reg: widths must be at least 1");
  end

  assign out_valid = (state != EMPTY);
  assign accept    = up.valid && ready;
  assign transfer  = out_valid && dn.ready;

  assign up.ready  = ready;
  assign dn.valid  = out_valid;
  assign dn.data   = main_data;
  // A bubble must never carry an architectural side effect downstream.
  assign dn.ctrl   = out_valid ? main_ctrl : CTRL_RST;

  // Next-state and entry-load decisions; flush overrides any transition.
  always_comb begin
    state_nxt     = state;
    main_data_nxt = main_data;
    main_ctrl_nxt = main_ctrl;
    skid_data_nxt = skid_data;
    skid_ctrl_nxt = skid_ctrl;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt     = FULL;
          main_data_nxt = up.data;
          main_ctrl_nxt = up.ctrl;
        end else begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (accept && transfer) begin
          state_nxt     = FULL;
          main_data_nxt = up.data;
          main_ctrl_nxt = up.ctrl;
        end else if (accept) begin
          state_nxt     = SKID;
          skid_data_nxt = up.data;
          skid_ctrl_nxt = up.ctrl;
        end else if (transfer) begin
          state_nxt = EMPTY;
        end else begin
          state_nxt = FULL;
        end
      end
      SKID: begin
        // in_ready is low here, so the only possible event is a drain.
        if (transfer) begin
          state_nxt     = FULL;
          main_data_nxt = skid_data;
          main_ctrl_nxt = skid_ctrl;
        end else begin
          state_nxt = SKID;
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      state_nxt = state_nxt;
    end
    // in_ready is registered: it looks one cycle ahead at the next state.
    ready_nxt = (state_nxt != SKID);
  end

  // State, handshake flop and entry storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      ready     <= 1'b1;
      main_data <= '0;
      main_ctrl <= CTRL_RST;
      skid_data <= '0;
      skid_ctrl <= CTRL_RST;
    end else begin
      state     <= state_nxt;
      ready     <= ready_nxt;
      main_data <= main_data_nxt;
      main_ctrl <= main_ctrl_nxt;
      skid_data <= skid_data_nxt;
      skid_ctrl <= skid_ctrl_nxt;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Saturating stall/bubble counters; cleared only by reset, not by flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !dn.ready && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
      if (!out_valid && (bubble_cnt != {CNT_W{1'b1}})) begin
        bubble_cnt <= bubble_cnt + CNT_ONE;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed vector table, hand
// sequences and a randomized run against a queue reference model.
module tb_pipe_stage_reg;

  localparam int              DW   = 16;
  localparam int              CW   = 5;
  localparam logic [CW-1:0]   CRST = 5'h15;
  localparam int              CNTW = 4;

  logic clk;
  logic rst;
  logic flush;
  int   checks;
  int   errors;

  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) up_if ();
  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) dn_if ();

`ifdef PIPE_STAGE_PERF_EN
  logic [CNTW-1:0] stall_cnt;
  logic [CNTW-1:0] bubble_cnt;
`endif

  pipe_stage_reg #(
    .DATA_W(DW), .CTRL_W(CW), .CTRL_RST(CRST), .CNT_W(CNTW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .up(up_if),
    .dn(dn_if)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt(stall_cnt),
    .bubble_cnt(bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [CW-1:0] ctrl_of(input logic [DW-1:0] d);
    return d[CW-1:0] ^ 5'h0a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic f, input logic iv,
                       input logic ordy, input logic [DW-1:0] d);
    rst            = r;
    flush          = f;
    up_if.valid    = iv;
    up_if.data     = d;
    up_if.ctrl     = ctrl_of(d);
    dn_if.ready    = ordy;
  endtask

  typedef struct {
    logic          rst;
    logic          flush;
    logic          iv;
    logic          ordy;
    logic [DW-1:0] d;
    logic          e_ov;
    logic          e_ir;
    logic          chk_d;
    logic [DW-1:0] e_d;
  } vec_t;

  vec_t vecs[16];

  logic [DW-1:0] q[$];
  logic [DW-1:0] seq;
  logic [DW-1:0] cur_d;
  logic          pend;
  logic          iv;
  logic          ordy;
  logic          fl;
  logic          m_ready;
  logic          acc;
  logic          xfer;

  initial begin
    checks = 0;
    errors = 0;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);

    //             rst   fl    iv    ordy  d         ov    ir    chkd  exp_d
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0011, 1'b0, 1'b1, 1'b1, 16'h0000};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0011, 1'b0, 1'b1, 1'b1, 16'h0000};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h00a1, 1'b1, 1'b1, 1'b1, 16'h00a1};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h00b2, 1'b1, 1'b0, 1'b1, 16'h00a1};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h00c3, 1'b1, 1'b0, 1'b1, 16'h00a1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h00b2};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h00c4, 1'b1, 1'b1, 1'b1, 16'h00c4};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h00d5, 1'b1, 1'b0, 1'b1, 16'h00c4};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h00e6, 1'b0, 1'b1, 1'b0, 16'h0000};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h00f7, 1'b1, 1'b1, 1'b1, 16'h00f7};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0018, 1'b1, 1'b1, 1'b1, 16'h0018};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0029, 1'b1, 1'b1, 1'b1, 16'h0029};
    vecs[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h003a, 1'b0, 1'b1, 1'b1, 16'h0000};

    // Directed vectors: reset, skid fill/drain, flush, pass-through, mid-op reset.
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].ordy, vecs[i].d);
      tick();
      chk($sformatf("vec%0d_out_valid", i), 32'(dn_if.valid), 32'(vecs[i].e_ov));
      chk($sformatf("vec%0d_in_ready", i), 32'(up_if.ready), 32'(vecs[i].e_ir));
      chk($sformatf("vec%0d_out_ctrl", i), 32'(dn_if.ctrl),
          32'(vecs[i].e_ov ? ctrl_of(vecs[i].e_d) : CRST));
      if (vecs[i].chk_d) begin
        chk($sformatf("vec%0d_out_data", i), 32'(dn_if.data), 32'(vecs[i].e_d));
      end
    end

    // Streaming: back-to-back 1..8 with downstream always ready.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
    tick();
    for (int k = 1; k <= 8; k++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1, DW'(k));
      tick();
      chk($sformatf("stream%0d_out_valid", k), 32'(dn_if.valid), 32'd1);
      chk($sformatf("stream%0d_out_data", k), 32'(dn_if.data), 32'(k));
      chk($sformatf("stream%0d_in_ready", k), 32'(up_if.ready), 32'd1);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    tick();
    chk("stream_drained", 32'(dn_if.valid), 32'd0);

`ifdef PIPE_STAGE_PERF_EN
    // Counters: one bubble cycle, then 20 stalled cycles saturate stall_cnt.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    chk("perf_rst_stall", 32'(stall_cnt), 32'd0);
    chk("perf_rst_bubble", 32'(bubble_cnt), 32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0055);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    for (int k = 0; k < 20; k++) tick();
    chk("perf_stall_sat", 32'(stall_cnt), 32'd15);
    chk("perf_bubble", 32'(bubble_cnt), 32'd1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    tick();
    chk("perf_flush_stall", 32'(stall_cnt), 32'd15);
    chk("perf_flush_bubble", 32'(bubble_cnt), 32'd1);
`endif

    // Randomized run against a FIFO-of-at-most-two reference model.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    q.delete();
    seq  = 16'h0100;
    pend = 1'b0;
    cur_d = seq;
    for (int c = 0; c < 10000; c++) begin
      if (!pend) begin
        iv    = ($urandom_range(0, 3) != 0);
        cur_d = seq;
      end else begin
        iv = 1'b1;
      end
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 31) == 0);
      drive(1'b0, fl, iv, ordy, cur_d);
      m_ready = (q.size() < 2);
      acc     = iv && m_ready;
      xfer    = (q.size() > 0) && ordy;
      tick();
      if (fl) begin
        q.delete();
      end else begin
        if (xfer) void'(q.pop_front());
        if (acc) q.push_back(cur_d);
      end
      if (iv && (acc || fl)) seq = seq + 16'd1;
      pend = iv && !acc && !fl;
      chk("rand_out_valid", 32'(dn_if.valid), 32'(q.size() > 0));
      chk("rand_in_ready", 32'(up_if.ready), 32'(q.size() < 2));
      if (q.size() > 0) begin
        chk("rand_out_data", 32'(dn_if.data), 32'(q[0]));
        chk("rand_out_ctrl", 32'(dn_if.ctrl), 32'(ctrl_of(q[0])));
      end else begin
        chk("rand_bubble_ctrl", 32'(dn_if.ctrl), 32'(CRST));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
